// File: rtl/st_video_pkg.sv
// st_video_pkg: shared constants and types for the video DMA.
// Word width, output sequencing offsets and parameter defaults.
package st_video_pkg;

    localparam int WORD_W          = 16;
    localparam int LOAD_OE_CYCLES  = 4;
    localparam int LOAD_STROBE_OFS = 3;

    localparam int DEF_ADDR_W         = 21;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_WORDS_PER_LINE = 80;
    localparam int DEF_LOAD_PERIOD    = 16;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/st_video_dma_if.sv
// st_video_dma_if: read request/acknowledge bus between the DMA
// (master) and the RAM arbiter (slave).
interface st_video_dma_if
    import st_video_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );

endinterface

// File: rtl/st_word_fifo.sv
// st_word_fifo: small synchronous FIFO of screen words.
// Flush wins over push/pop; pop on empty is ignored.
module st_word_fifo
    import st_video_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic [LW-1:0]     level,
    output logic              empty,
    output logic              full
);

    localparam int PW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [LW-1:0]     lvl_q, lvl_d;
    logic              do_push;
    logic              do_pop;

    assign empty   = (lvl_q == '0);
    assign full    = (lvl_q == LW'(DEPTH));
    assign level   = lvl_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointer, level and storage update.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        lvl_d = lvl_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            lvl_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                lvl_d = lvl_q + LW'(1);
            end else if (do_pop && !do_push) begin
                lvl_d = lvl_q - LW'(1);
            end
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

endmodule

// File: rtl/st_video_dma.sv
// st_video_dma: video DMA initiator feeding the shifter.
// Prefetches screen words into a FIFO and emits one per LOAD slot.
module st_video_dma
    import st_video_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int LOAD_PERIOD    = DEF_LOAD_PERIOD
) (
    input  logic              CLOCK_32,
    input  logic              RESET,
    input  logic              vbase_wr,
    input  logic [ADDR_W-1:0] vbase_in,
    input  logic              vsync,
    input  logic              de,
    st_video_dma_if.master    mem,
    output logic              load,
    output logic [WORD_W-1:0] data_out,
    output logic              data_oe,
    output logic [ADDR_W-1:0] vaddr,
    output logic              underrun
);

    localparam int LW  = $clog2(FIFO_DEPTH + 1);
    localparam int FW  = $clog2(WORDS_PER_LINE + 1);
    localparam int PHW = $clog2(LOAD_PERIOD);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] vbase_q, vbase_d;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d;
    logic              drop_q, drop_d;
    logic [FW-1:0]     fetched_q, fetched_d;
    logic [FW-1:0]     loaded_q, loaded_d;
    logic [PHW-1:0]    phase_q, phase_d;
    logic              de_q, de_d;
    logic [2:0]        slot_q, slot_d;
    logic [WORD_W-1:0] data_out_q, data_out_d;
    logic              data_oe_q, data_oe_d;
    logic              load_q, load_d;
    logic              underrun_q, underrun_d;

    logic              fifo_push;
    logic              fifo_empty;
    logic              fifo_full;
    logic [LW-1:0]     fifo_level;
    logic [WORD_W-1:0] fifo_dout;
    logic              ack_take;
    logic              pop_go;
    logic              fetch_ok;
    logic              de_fall;

    // A word ack'd after vsync belongs to the old frame and is dropped.
    assign ack_take  = (state_q == F_REQ) && mem.mem_ack;
    assign fifo_push = ack_take && !drop_q && !vsync;
    assign de_fall   = de_q && !de;
    assign pop_go    = de && (phase_q == '0) && !vsync &&
                       (loaded_q < FW'(WORDS_PER_LINE));
    assign fetch_ok  = !vsync && (fetched_q < FW'(WORDS_PER_LINE)) &&
                       ((LW + 1)'(fifo_level) + (LW + 1)'(state_q == F_REQ)
                        < (LW + 1)'(FIFO_DEPTH));

    st_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_32),
        .rst   (RESET),
        .push  (fifo_push),
        .pop   (pop_go),
        .flush (vsync),
        .din   (mem.mem_data),
        .dout  (fifo_dout),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Fetch FSM state register.
    always_ff @(posedge CLOCK_32) begin
        if (RESET) begin
            state_q <= F_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch FSM next state: one request outstanding, held until ack.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            F_IDLE:  if (fetch_ok) state_d = F_REQ;
            F_REQ:   if (mem.mem_ack) state_d = F_IDLE;
            default: state_d = F_IDLE;
        endcase
    end

    // Fetch FSM outputs: request and its latched address.
    always_comb begin
        mem.mem_req  = (state_q == F_REQ);
        mem.mem_addr = addr_q;
    end

    // Address, line counters, slot phase and output sequencing.
    always_comb begin
        vbase_d    = vbase_wr ? vbase_in : vbase_q;
        addr_d     = (state_q == F_IDLE && fetch_ok) ? vaddr_q : addr_q;
        de_d       = de;
        vaddr_d    = vaddr_q;
        drop_d     = drop_q;
        fetched_d  = fetched_q;
        loaded_d   = loaded_q;
        underrun_d = underrun_q;
        data_out_d = data_out_q;

        if (vsync) begin
            vaddr_d = vbase_d;
        end else if (fifo_push) begin
            vaddr_d = vaddr_q + ADDR_W'(1);
        end

        if (ack_take) begin
            drop_d = 1'b0;
        end else if (vsync && state_q == F_REQ) begin
            drop_d = 1'b1;
        end

        if (vsync) begin
            fetched_d = '0;
        end else if (de_fall) begin
            fetched_d = FW'(fifo_push);
        end else if (fifo_push) begin
            fetched_d = fetched_q + FW'(1);
        end

        if (vsync || de_fall) begin
            loaded_d = '0;
        end else if (pop_go) begin
            loaded_d = loaded_q + FW'(1);
        end

        phase_d = '0;
        if (de && phase_q != PHW'(LOAD_PERIOD - 1)) begin
            phase_d = phase_q + PHW'(1);
        end

        slot_d = '0;
        if (pop_go) begin
            slot_d = 3'd1;
        end else if (slot_q != '0 && slot_q < 3'(LOAD_OE_CYCLES)) begin
            slot_d = slot_q + 3'd1;
        end
        data_oe_d = (slot_d != '0);
        load_d    = (slot_d == 3'(LOAD_STROBE_OFS));

        if (pop_go) begin
            data_out_d = fifo_empty ? '0 : fifo_dout;
        end

        if (vsync) begin
            underrun_d = 1'b0;
        end else if (pop_go && fifo_empty) begin
            underrun_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge CLOCK_32) begin
        if (RESET) begin
            addr_q     <= '0;
            vbase_q    <= '0;
            vaddr_q    <= '0;
            drop_q     <= 1'b0;
            fetched_q  <= '0;
            loaded_q   <= '0;
            phase_q    <= '0;
            de_q       <= 1'b0;
            slot_q     <= '0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            load_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            vbase_q    <= vbase_d;
            vaddr_q    <= vaddr_d;
            drop_q     <= drop_d;
            fetched_q  <= fetched_d;
            loaded_q   <= loaded_d;
            phase_q    <= phase_d;
            de_q       <= de_d;
            slot_q     <= slot_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            load_q     <= load_d;
            underrun_q <= underrun_d;
        end
    end

    assign load     = load_q;
    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign vaddr    = vaddr_q;
    assign underrun = underrun_q;

    // Requests are only issued with room left, so a push never meets a full FIFO.
    a_no_push_full: assert property (
        @(posedge CLOCK_32) disable iff (RESET) !(fifo_push && fifo_full));

endmodule
